// File: rtl/alu_cmp_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmp_monitor_pkg
//  Description : Shared constants for the dual-ALU compare monitor: log record
//                field layout, cause bit encoding and default sizing.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_cmp_monitor_pkg;

  // Default sizing
  localparam int c_DEF_CNT_W     = 16;
  localparam int c_DEF_LOG_DEPTH = 4;

  // Log record layout: {alu_out1, alu_out2, carry_out1, carry_out2, cause, seq}
  localparam int c_REC_W      = 16;
  localparam int c_ALU_W      = 4;
  localparam int c_SEQ_W      = 4;
  localparam int c_CAUSE_W    = 2;
  localparam int c_SEQ_LSB    = 0;
  localparam int c_CAUSE_LSB  = 4;
  localparam int c_CARRY2_BIT = 6;
  localparam int c_CARRY1_BIT = 7;
  localparam int c_ALU2_LSB   = 8;
  localparam int c_ALU1_LSB   = 12;

  // Cause bit encoding
  localparam int c_CAUSE_CARRY_BIT = 0;
  localparam int c_CAUSE_DATA_BIT  = 1;

  // Assemble one log record from its fields
  function automatic logic [c_REC_W-1:0] pack_record(
    input logic [c_ALU_W-1:0]   alu1,
    input logic [c_ALU_W-1:0]   alu2,
    input logic                 carry1,
    input logic                 carry2,
    input logic [c_CAUSE_W-1:0] cause,
    input logic [c_SEQ_W-1:0]   seq
  );
    logic [c_REC_W-1:0] rec;
    rec                           = '0;
    rec[c_ALU1_LSB +: c_ALU_W]    = alu1;
    rec[c_ALU2_LSB +: c_ALU_W]    = alu2;
    rec[c_CARRY1_BIT]             = carry1;
    rec[c_CARRY2_BIT]             = carry2;
    rec[c_CAUSE_LSB +: c_CAUSE_W] = cause;
    rec[c_SEQ_LSB +: c_SEQ_W]     = seq;
    return rec;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmp_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmp_monitor_if
//  Description : Sample, control and status bundle between the dual-ALU source
//                (master) and the compare monitor (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_cmp_monitor_if
  import alu_cmp_monitor_pkg::*;
#(
  parameter int CNT_W     = c_DEF_CNT_W,
  parameter int LOG_DEPTH = c_DEF_LOG_DEPTH
);
  localparam int c_LC_W = $clog2(LOG_DEPTH) + 1;

  // Sample from the dual ALU
  logic               in_valid;
  logic [3:0]         alu_out1;
  logic [3:0]         alu_out2;
  logic               carry_out1;
  logic               carry_out2;
  logic [3:0]         x;
  logic               y;
  // Control
  logic               clr;
  logic [CNT_W-1:0]   thresh;
  logic               rd_req;
  // Status / log read port
  logic               rd_valid;
  logic [c_REC_W-1:0] rd_data;
  logic [c_LC_W-1:0]  log_count;
  logic               log_overflow;
  logic [CNT_W-1:0]   sample_cnt;
  logic [CNT_W-1:0]   mismatch_cnt;
  logic               err_sticky;
  logic               alarm;
  logic               consistency_err;

  modport master (
    output in_valid, alu_out1, alu_out2, carry_out1, carry_out2, x, y,
    output clr, thresh, rd_req,
    input  rd_valid, rd_data, log_count, log_overflow, sample_cnt,
    input  mismatch_cnt, err_sticky, alarm, consistency_err
  );

  modport slave (
    input  in_valid, alu_out1, alu_out2, carry_out1, carry_out2, x, y,
    input  clr, thresh, rd_req,
    output rd_valid, rd_data, log_count, log_overflow, sample_cnt,
    output mismatch_cnt, err_sticky, alarm, consistency_err
  );

endinterface
`default_nettype wire

// File: rtl/alu_cmp_monitor_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_log_fifo
//  Description : Show-ahead synchronous FIFO holding mismatch records, with
//                occupancy count and full/empty flags. A push while full is
//                accepted only if a pop frees a slot in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmp_log_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       i_clr,
  input  wire logic                       i_push,
  input  wire logic [W-1:0]               i_push_data,
  input  wire logic                       i_pop,
  output logic      [W-1:0]               o_rd_data,
  output logic      [$clog2(DEPTH):0]     o_count,
  output logic                            o_full,
  output logic                            o_empty
);
  localparam int               c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]    c_FULL = (c_AW+1)'(DEPTH);

  logic [W-1:0]    r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_wr;
  logic w_rd;

  assign w_full  = (r_count == c_FULL);
  assign w_empty = (r_count == '0);
  // Full slots only take a write when a read leaves in the same cycle
  assign w_wr    = i_push & (~w_full | i_pop) & ~i_clr;
  // Reads of an empty FIFO are ignored
  assign w_rd    = i_pop & ~w_empty & ~i_clr;

  // Pointer and occupancy bookkeeping; clear empties the FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Record storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_full    = w_full;
  assign o_empty   = w_empty;

endmodule
`default_nettype wire

// File: rtl/alu_cmp_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmp_monitor
//  Description : Watches a lock-step dual-ALU pair. Each valid sample is
//                registered, compared, counted and, on mismatch, logged into
//                a small FIFO. Also cross-checks the upstream compare bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmp_monitor
  import alu_cmp_monitor_pkg::*;
#(
  parameter int CNT_W     = c_DEF_CNT_W,
  parameter int LOG_DEPTH = c_DEF_LOG_DEPTH
) (
  input  wire logic         wb_clk_i,
  input  wire logic         wb_rst_i,
  alu_cmp_monitor_if.slave  mon
);
  localparam int               c_LC_W    = $clog2(LOG_DEPTH) + 1;
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  // Input stage
  logic       r_s_valid;
  logic [3:0] r_s_a1;
  logic [3:0] r_s_a2;
  logic       r_s_c1;
  logic       r_s_c2;
  logic [3:0] r_s_x;
  logic       r_s_y;

  // Counters and flags
  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_mismatch_cnt;
  logic             r_err_sticky;
  logic             r_cons_err;
  logic             r_overflow;

  // Compare results of the registered sample
  logic                 w_data_mis;
  logic                 w_carry_mis;
  logic                 w_mis;
  logic                 w_cons_bad;
  logic [c_CAUSE_W-1:0] w_cause;
  logic                 w_take;
  logic                 w_push;
  logic                 w_pop;
  logic [c_REC_W-1:0]   w_record;

  // Log status
  logic [c_REC_W-1:0] w_rd_data;
  logic [c_LC_W-1:0]  w_count;
  logic               w_full;
  logic               w_empty;

  // Register each accepted sample; clear drops whatever would be captured
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_s_valid <= 1'b0;
      r_s_a1    <= '0;
      r_s_a2    <= '0;
      r_s_c1    <= 1'b0;
      r_s_c2    <= 1'b0;
      r_s_x     <= '0;
      r_s_y     <= 1'b0;
    end else begin
      r_s_valid <= mon.in_valid & ~mon.clr;
      if (mon.in_valid) begin
        r_s_a1 <= mon.alu_out1;
        r_s_a2 <= mon.alu_out2;
        r_s_c1 <= mon.carry_out1;
        r_s_c2 <= mon.carry_out2;
        r_s_x  <= mon.x;
        r_s_y  <= mon.y;
      end
    end
  end

  // Classify the registered sample
  always_comb begin
    w_data_mis                 = (r_s_a1 != r_s_a2);
    w_carry_mis                = (r_s_c1 != r_s_c2);
    w_mis                      = w_data_mis | w_carry_mis;
    w_cons_bad                 = (r_s_x != (r_s_a1 ^ r_s_a2)) | (r_s_y != (r_s_c1 ^ r_s_c2));
    w_cause                    = '0;
    w_cause[c_CAUSE_DATA_BIT]  = w_data_mis;
    w_cause[c_CAUSE_CARRY_BIT] = w_carry_mis;
  end

  // A clear in this cycle also discards the sample sitting in the stage
  assign w_take   = r_s_valid & ~mon.clr;
  assign w_push   = w_take & w_mis;
  assign w_pop    = mon.rd_req & ~w_empty;
  // seq tags the record with the sample count before this sample's increment
  assign w_record = pack_record(r_s_a1, r_s_a2, r_s_c1, r_s_c2, w_cause,
                                r_sample_cnt[c_SEQ_W-1:0]);

  // Saturating counters and sticky flags, clear taking priority
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_sample_cnt   <= '0;
      r_mismatch_cnt <= '0;
      r_err_sticky   <= 1'b0;
      r_cons_err     <= 1'b0;
      r_overflow     <= 1'b0;
    end else if (mon.clr) begin
      r_sample_cnt   <= '0;
      r_mismatch_cnt <= '0;
      r_err_sticky   <= 1'b0;
      r_cons_err     <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      if (w_take) begin
        if (r_sample_cnt != c_CNT_MAX) r_sample_cnt <= r_sample_cnt + 1'b1;
        if (w_mis) begin
          if (r_mismatch_cnt != c_CNT_MAX) r_mismatch_cnt <= r_mismatch_cnt + 1'b1;
          r_err_sticky <= 1'b1;
        end
        if (w_cons_bad) r_cons_err <= 1'b1;
      end
      // A record is lost only when the log is full and nothing leaves
      if (w_push & w_full & ~w_pop) r_overflow <= 1'b1;
    end
  end

  cmp_log_fifo #(
    .DEPTH (LOG_DEPTH),
    .W     (c_REC_W)
  ) u_log (
    .clk         (wb_clk_i),
    .rst         (wb_rst_i),
    .i_clr       (mon.clr),
    .i_push      (w_push),
    .i_push_data (w_record),
    .i_pop       (mon.rd_req),
    .o_rd_data   (w_rd_data),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign mon.rd_valid        = ~w_empty;
  assign mon.rd_data         = w_rd_data;
  assign mon.log_count       = w_count;
  assign mon.log_overflow    = r_overflow;
  assign mon.sample_cnt      = r_sample_cnt;
  assign mon.mismatch_cnt    = r_mismatch_cnt;
  assign mon.err_sticky      = r_err_sticky;
  assign mon.consistency_err = r_cons_err;
  assign mon.alarm           = (mon.thresh != '0) && (r_mismatch_cnt >= mon.thresh);

endmodule
`default_nettype wire

// File: tb/tb_alu_cmp_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_cmp_monitor
//  Description : Directed bench for alu_cmp_monitor. Expected log records are
//                queued at issue time and checked by a monitor on every pop;
//                status outputs are checked against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmp_monitor;

  logic clk;
  logic rst;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] exp_q[$];

  alu_cmp_monitor_if #(.CNT_W(16), .LOG_DEPTH(4)) bus ();

  alu_cmp_monitor #(
    .CNT_W     (16),
    .LOG_DEPTH (4)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .mon      (bus)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_raw(input logic [3:0] a1, input logic [3:0] a2,
                            input logic c1, input logic c2,
                            input logic [3:0] xv, input logic yv);
    bus.in_valid   = 1'b1;
    bus.alu_out1   = a1;
    bus.alu_out2   = a2;
    bus.carry_out1 = c1;
    bus.carry_out2 = c2;
    bus.x          = xv;
    bus.y          = yv;
    step();
    bus.in_valid   = 1'b0;
  endtask

  task automatic sample(input logic [3:0] a1, input logic [3:0] a2,
                        input logic c1, input logic c2);
    sample_raw(a1, a2, c1, c2, a1 ^ a2, c1 ^ c2);
  endtask

  task automatic pop_n(input int n);
    bus.rd_req = 1'b1;
    repeat (n) step();
    bus.rd_req = 1'b0;
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    exp_q.delete();
  endtask

  // Scoreboard monitor: every accepted pop must match the oldest expected record
  always @(negedge clk) begin
    if (!rst && bus.rd_valid && bus.rd_req) begin
      if (exp_q.size() == 0) begin
        chk("log_pop_unexpected", {16'h0, bus.rd_data}, 32'hFFFF_FFFF);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("log_pop_record", {16'h0, bus.rd_data}, {16'h0, e});
      end
    end
  end

  // Runaway guard
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] c_six[4];
    logic [15:0] c_full[4];
    c_six  = '{16'h1220, 16'h2321, 16'h3422, 16'h4523};
    c_full = '{16'hA520, 16'hA521, 16'hA522, 16'hA523};

    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.alu_out1   = '0;
    bus.alu_out2   = '0;
    bus.carry_out1 = 1'b0;
    bus.carry_out2 = 1'b0;
    bus.x          = '0;
    bus.y          = 1'b0;
    bus.clr        = 1'b0;
    bus.thresh     = '0;
    bus.rd_req     = 1'b0;
    repeat (2) step();

    // Reset state
    chk("rst_rd_valid",     32'(bus.rd_valid),        0);
    chk("rst_log_count",    32'(bus.log_count),       0);
    chk("rst_overflow",     32'(bus.log_overflow),    0);
    chk("rst_sample_cnt",   32'(bus.sample_cnt),      0);
    chk("rst_mismatch_cnt", 32'(bus.mismatch_cnt),    0);
    chk("rst_err_sticky",   32'(bus.err_sticky),      0);
    chk("rst_cons_err",     32'(bus.consistency_err), 0);
    chk("rst_alarm",        32'(bus.alarm),           0);
    rst = 1'b0;
    step();

    // Two matching samples
    sample(4'd5, 4'd5, 1'b0, 1'b0);
    sample(4'd3, 4'd3, 1'b1, 1'b1);
    step();
    chk("match_sample_cnt",   32'(bus.sample_cnt),      2);
    chk("match_mismatch_cnt", 32'(bus.mismatch_cnt),    0);
    chk("match_rd_valid",     32'(bus.rd_valid),        0);
    chk("match_err_sticky",   32'(bus.err_sticky),      0);
    chk("match_cons_err",     32'(bus.consistency_err), 0);

    // Single data+carry mismatch, seq 0 after clear
    do_clr();
    chk("clr_sample_cnt", 32'(bus.sample_cnt), 0);
    exp_q.push_back(16'h9870);
    sample(4'd9, 4'd8, 1'b0, 1'b1);
    step();
    chk("mis1_mismatch_cnt", 32'(bus.mismatch_cnt), 1);
    chk("mis1_err_sticky",   32'(bus.err_sticky),   1);
    chk("mis1_log_count",    32'(bus.log_count),    1);
    chk("mis1_rd_data",      32'(bus.rd_data),      32'h9870);
    pop_n(1);
    chk("mis1_empty_after_pop", 32'(bus.rd_valid), 0);
    pop_n(1);
    chk("pop_empty_log_count", 32'(bus.log_count), 0);

    // Six mismatches, no reads: first four kept, overflow flagged
    do_clr();
    for (int i = 0; i < 4; i++) exp_q.push_back(c_six[i]);
    for (int i = 0; i < 6; i++) sample(4'(i + 1), 4'(i + 2), 1'b0, 1'b0);
    step();
    chk("ovf_log_count",    32'(bus.log_count),    4);
    chk("ovf_overflow",     32'(bus.log_overflow), 1);
    chk("ovf_mismatch_cnt", 32'(bus.mismatch_cnt), 6);
    chk("ovf_sample_cnt",   32'(bus.sample_cnt),   6);
    pop_n(4);
    chk("ovf_drained_count", 32'(bus.log_count),    0);
    chk("ovf_drained_valid", 32'(bus.rd_valid),     0);
    chk("ovf_sticky_kept",   32'(bus.log_overflow), 1);

    // Full log, push and pop in the same cycle
    do_clr();
    for (int i = 0; i < 4; i++) exp_q.push_back(c_full[i]);
    for (int i = 0; i < 4; i++) sample(4'hA, 4'h5, 1'b0, 1'b0);
    step();
    chk("full_log_count", 32'(bus.log_count),    4);
    chk("full_overflow",  32'(bus.log_overflow), 0);
    exp_q.push_back(16'hF0B4);
    sample(4'hF, 4'h0, 1'b1, 1'b0);
    pop_n(1);
    chk("pushpop_log_count", 32'(bus.log_count),    4);
    chk("pushpop_overflow",  32'(bus.log_overflow), 0);
    pop_n(4);
    chk("pushpop_drained", 32'(bus.log_count), 0);

    // Alarm threshold, then clear
    do_clr();
    bus.thresh = 16'd3;
    sample(4'd1, 4'd0, 1'b0, 1'b0);
    sample(4'd1, 4'd0, 1'b0, 1'b0);
    step();
    chk("alarm_below_cnt", 32'(bus.mismatch_cnt), 2);
    chk("alarm_below",     32'(bus.alarm),        0);
    sample(4'd1, 4'd0, 1'b0, 1'b0);
    step();
    chk("alarm_at_cnt", 32'(bus.mismatch_cnt), 3);
    chk("alarm_at",     32'(bus.alarm),        1);
    // Sample still in the input stage when clear hits must be discarded
    sample(4'd1, 4'd0, 1'b0, 1'b0);
    do_clr();
    step();
    chk("clr_mismatch_cnt", 32'(bus.mismatch_cnt), 0);
    chk("clr_sample_cnt2",  32'(bus.sample_cnt),   0);
    chk("clr_err_sticky",   32'(bus.err_sticky),   0);
    chk("clr_log_count",    32'(bus.log_count),    0);
    chk("clr_alarm",        32'(bus.alarm),        0);
    bus.thresh = '0;

    // Inconsistent upstream compare on a matching sample
    sample_raw(4'd6, 4'd6, 1'b0, 1'b0, 4'h1, 1'b0);
    step();
    chk("cons_err",          32'(bus.consistency_err), 1);
    chk("cons_mismatch_cnt", 32'(bus.mismatch_cnt),    0);
    chk("cons_sample_cnt",   32'(bus.sample_cnt),      1);

    // Asynchronous reset with a mismatch in flight
    sample(4'd2, 4'd1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("arst_sample_cnt",   32'(bus.sample_cnt),      0);
    chk("arst_mismatch_cnt", 32'(bus.mismatch_cnt),    0);
    chk("arst_cons_err",     32'(bus.consistency_err), 0);
    chk("arst_rd_valid",     32'(bus.rd_valid),        0);
    step();
    rst = 1'b0;
    step();
    chk("arst_lost_sample", 32'(bus.sample_cnt), 0);

    // First sample after reset is seq 0; thresh=0 keeps alarm off
    exp_q.push_back(16'h73E0);
    sample(4'd7, 4'd3, 1'b1, 1'b1);
    step();
    chk("post_rst_sample_cnt", 32'(bus.sample_cnt), 1);
    chk("post_rst_alarm_off",  32'(bus.alarm),      0);
    pop_n(1);

    step();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
